// File: rtl/swd_pkg.sv
// Shared SWD transaction constants: ack encodings, response status codes and
// the sequencer state encoding.
package swd_pkg;

  localparam logic [2:0] ACK_OK    = 3'b001;
  localparam logic [2:0] ACK_WAIT  = 3'b010;
  localparam logic [2:0] ACK_FAULT = 3'b100;

  localparam logic [1:0] STATUS_OK    = 2'd0;
  localparam logic [1:0] STATUS_WAIT  = 2'd1;
  localparam logic [1:0] STATUS_FAULT = 2'd2;
  localparam logic [1:0] STATUS_ERR   = 2'd3;

  localparam logic [1:0] RDBUFF_ADDR = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_RUN,
    S_EVAL,
    S_BACKOFF,
    S_RESP
  } state_t;

endpackage

// File: rtl/swd_xfer_seq.sv
// DAP command sequencer in front of swdIF: one command at a time, WAIT retry
// with fixed backoff, optional RDBUFF follow-up for posted AP reads.
module swd_xfer_seq
  import swd_pkg::*;
#(
  parameter int MAX_RETRY   = 8,
  parameter int BACKOFF     = 16,
  parameter int RDBUFF_AUTO = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic [1:0]                     cmd_addr32,
  input  logic                           cmd_rnw,
  input  logic                           cmd_apndp,
  input  logic [31:0]                    cmd_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic [2:0]                     rsp_ack,
  output logic                           rsp_perr,
  output logic [$clog2(MAX_RETRY+1)-1:0] rsp_retries,
  output logic [1:0]                     rsp_status,
  output logic                           swd_go,
  output logic [1:0]                     swd_addr32,
  output logic                           swd_rnw,
  output logic                           swd_apndp,
  output logic [31:0]                    swd_dwrite,
  input  logic                           swd_done,
  input  logic [2:0]                     swd_ack,
  input  logic [31:0]                    swd_dread,
  input  logic                           swd_perr
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int BW = (BACKOFF > 1) ? $clog2(BACKOFF) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  function automatic logic [RW-1:0] sat_inc(input logic [RW-1:0] v);
    return (v == RETRY_MAX) ? v : v + 1'b1;
  endfunction

  state_t          state_q, state_d;
  logic [RW-1:0]   retries_q;
  logic            phase_q;
  logic [BW-1:0]   bo_q;
  logic            ready_q;

  state_t          ev_next;
  logic [1:0]      ev_status;
  logic            ev_retry;
  logic            ev_rdbuff;
  logic            cmd_fire;

  assign swd_go    = (state_q == S_LAUNCH);
  assign rsp_valid = (state_q == S_RESP);
  // ready_q masks cmd_ready for the first cycle out of reset
  assign cmd_ready = ready_q && (state_q == S_IDLE) && swd_done && !rsp_valid;
  assign cmd_fire  = cmd_valid && cmd_ready;

  always_comb begin
    ev_next   = S_RESP;
    ev_status = STATUS_OK;
    ev_retry  = 1'b0;
    ev_rdbuff = 1'b0;
    if (swd_perr) begin
      ev_status = STATUS_ERR;
    end else if (swd_ack == ACK_WAIT) begin
      if (retries_q < RETRY_MAX) begin
        ev_retry = 1'b1;
        ev_next  = S_BACKOFF;
      end else begin
        ev_status = STATUS_WAIT;
      end
    end else if (swd_ack == ACK_FAULT) begin
      ev_status = STATUS_FAULT;
    end else if (swd_ack != ACK_OK) begin
      ev_status = STATUS_ERR;
    end else if ((RDBUFF_AUTO != 0) && swd_apndp && swd_rnw && !phase_q) begin
      ev_rdbuff = 1'b1;
      ev_next   = S_LAUNCH;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:    if (cmd_fire) state_d = S_LAUNCH;
      S_LAUNCH:  if (!swd_done) state_d = S_RUN;
      S_RUN:     if (swd_done) state_d = S_EVAL;
      S_EVAL:    state_d = ev_next;
      S_BACKOFF: if (bo_q == '0) state_d = S_LAUNCH;
      S_RESP:    if (rsp_ready) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ready_q     <= 1'b0;
      retries_q   <= '0;
      phase_q     <= 1'b0;
      bo_q        <= '0;
      swd_addr32  <= '0;
      swd_rnw     <= 1'b0;
      swd_apndp   <= 1'b0;
      swd_dwrite  <= '0;
      rsp_rdata   <= '0;
      rsp_ack     <= '0;
      rsp_perr    <= 1'b0;
      rsp_retries <= '0;
      rsp_status  <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (cmd_fire) begin
            swd_addr32 <= cmd_addr32;
            swd_rnw    <= cmd_rnw;
            swd_apndp  <= cmd_apndp;
            swd_dwrite <= cmd_wdata;
            retries_q  <= '0;
            phase_q    <= 1'b0;
          end
        end
        S_EVAL: begin
          rsp_ack     <= swd_ack;
          rsp_perr    <= swd_perr;
          rsp_rdata   <= swd_rnw ? swd_dread : '0;
          rsp_status  <= ev_status;
          rsp_retries <= retries_q;
          bo_q        <= BW'(BACKOFF - 1);
          if (ev_retry) retries_q <= sat_inc(retries_q);
          if (ev_rdbuff) begin
            phase_q    <= 1'b1;
            swd_addr32 <= RDBUFF_ADDR;
            swd_apndp  <= 1'b0;
            swd_rnw    <= 1'b1;
          end
        end
        S_BACKOFF: if (bo_q != '0) bo_q <= bo_q - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_swd_xfer_seq.sv
// Randomised scoreboard bench for swd_xfer_seq with a reactive swdIF model and
// a transaction-level reference of the retry/RDBUFF rules.
module tb_swd_xfer_seq;
  import swd_pkg::*;

  localparam int MAXR = 8;
  localparam int BO   = 16;
  localparam int RW   = $clog2(MAXR + 1);

  typedef struct {
    logic [2:0]  ack;
    logic [31:0] dread;
    logic        perr;
  } resp_t;

  typedef struct {
    logic [1:0]  addr;
    logic        rnw;
    logic        apndp;
    logic [31:0] wdata;
    int          gap;
  } xfer_t;

  typedef struct {
    logic [31:0] rdata;
    logic [2:0]  ack;
    logic        perr;
    int          retries;
    logic [1:0]  status;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_addr32 = '0;
  logic          cmd_rnw = 1'b0;
  logic          cmd_apndp = 1'b0;
  logic [31:0]   cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [31:0]   rsp_rdata;
  logic [2:0]    rsp_ack;
  logic          rsp_perr;
  logic [RW-1:0] rsp_retries;
  logic [1:0]    rsp_status;
  logic          swd_go;
  logic [1:0]    swd_addr32;
  logic          swd_rnw;
  logic          swd_apndp;
  logic [31:0]   swd_dwrite;
  logic          swd_done;
  logic [2:0]    swd_ack;
  logic [31:0]   swd_dread;
  logic          swd_perr;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  xfer_t xq[$];
  resp_t sq[$];
  rsp_t  eq[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  swd_xfer_seq #(.MAX_RETRY(MAXR), .BACKOFF(BO), .RDBUFF_AUTO(1)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr32(cmd_addr32),
    .cmd_rnw(cmd_rnw), .cmd_apndp(cmd_apndp), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_ack(rsp_ack), .rsp_perr(rsp_perr), .rsp_retries(rsp_retries),
    .rsp_status(rsp_status),
    .swd_go(swd_go), .swd_addr32(swd_addr32), .swd_rnw(swd_rnw),
    .swd_apndp(swd_apndp), .swd_dwrite(swd_dwrite),
    .swd_done(swd_done), .swd_ack(swd_ack), .swd_dread(swd_dread),
    .swd_perr(swd_perr)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic resp_t mk(input logic [2:0] a, input logic [31:0] d, input logic p);
    resp_t r;
    r.ack = a; r.dread = d; r.perr = p;
    return r;
  endfunction

  function automatic resp_t rand_resp(input bit all_wait);
    logic [2:0] bad [5];
    int k;
    bad = '{3'b000, 3'b011, 3'b101, 3'b110, 3'b111};
    k = $urandom_range(0, 99);
    if (all_wait || (k >= 45 && k < 75)) return mk(ACK_WAIT, $urandom, 1'b0);
    if (k < 45) return mk(ACK_OK, $urandom, 1'b0);
    if (k < 85) return mk(ACK_FAULT, $urandom, 1'b0);
    if (k < 93) return mk(bad[$urandom_range(0, 4)], $urandom, 1'b0);
    return mk(3'($urandom_range(0, 7)), $urandom, 1'b1);
  endfunction

  // Reference: walk the transfer script by the retry/RDBUFF rules and queue
  // the transfers the DUT must issue, the swdIF replies and the final response.
  task automatic plan(input logic [1:0] a, input logic rnw, input logic ap,
                      input logic [31:0] wd, input resp_t s[$]);
    xfer_t x;
    rsp_t  r;
    int    retries = 0;
    bit    rdb = 0;
    bit    fin = 0;
    int    gap = 0;
    x.addr = a; x.rnw = rnw; x.apndp = ap; x.wdata = wd;
    r = '{default: '0};
    for (int i = 0; i < s.size() && !fin; i++) begin
      x.gap = gap;
      xq.push_back(x);
      sq.push_back(s[i]);
      r.ack = s[i].ack; r.perr = s[i].perr;
      r.rdata = x.rnw ? s[i].dread : 32'h0;
      r.retries = retries;
      if (s[i].perr) begin r.status = 2'd3; fin = 1; end
      else if (s[i].ack == 3'b010 && retries < MAXR) begin retries++; gap = BO + 2; end
      else if (s[i].ack == 3'b010) begin r.status = 2'd1; fin = 1; end
      else if (s[i].ack == 3'b100) begin r.status = 2'd2; fin = 1; end
      else if (s[i].ack != 3'b001) begin r.status = 2'd3; fin = 1; end
      else if (x.apndp && x.rnw && !rdb) begin
        rdb = 1; x.addr = 2'b11; x.apndp = 1'b0; x.rnw = 1'b1; gap = 2;
      end else begin r.status = 2'd0; fin = 1; end
    end
    eq.push_back(r);
  endtask

  task automatic issue(input logic [1:0] a, input logic rnw, input logic ap, input logic [31:0] wd);
    int n = 0;
    @(negedge clk);
    cmd_addr32 = a; cmd_rnw = rnw; cmd_apndp = ap; cmd_wdata = wd; cmd_valid = 1'b1;
    while (!cmd_ready && n < 200) begin @(negedge clk); n++; end
    check("cmd_accept", cmd_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_wdata = $urandom;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((eq.size() != 0 || xq.size() != 0) && n < 4000) begin @(negedge clk); n++; end
    check("rsp_complete", (eq.size() == 0 && xq.size() == 0), 1'b1);
    xq.delete(); sq.delete(); eq.delete();
  endtask

  task automatic run(input logic [1:0] a, input logic rnw, input logic ap,
                     input logic [31:0] wd, input resp_t s[$]);
    plan(a, rnw, ap, wd, s);
    issue(a, rnw, ap, wd);
    wait_idle();
    repeat ($urandom_range(0, 3)) @(negedge clk);
  endtask

  // swdIF model: on go, drop done after 0..2 cycles, finish 1..4 cycles later.
  initial begin : swd_model
    int st, cnt, last_done;
    resp_t r;
    xfer_t x;
    st = 0; cnt = 0; last_done = 0;
    swd_done = 1'b1; swd_ack = '0; swd_dread = '0; swd_perr = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        st = 0; swd_done = 1'b1;
      end else begin
        case (st)
          0: if (swd_go) begin
            check("xfer_expected", (xq.size() != 0), 1'b1);
            if (xq.size() != 0) begin
              x = xq.pop_front();
              check("xfer_addr", swd_addr32, x.addr);
              check("xfer_rnw", swd_rnw, x.rnw);
              check("xfer_apndp", swd_apndp, x.apndp);
              if (!x.rnw) check("xfer_wdata", swd_dwrite, x.wdata);
              if (x.gap != 0) check("xfer_gap", cyc - last_done, x.gap);
            end
            cnt = $urandom_range(0, 2);
            st = 1;
          end
          2: begin
            cnt--;
            if (cnt == 0) begin
              r = (sq.size() != 0) ? sq.pop_front() : mk(ACK_OK, 32'h0, 1'b0);
              swd_ack = r.ack; swd_dread = r.dread; swd_perr = r.perr;
              swd_done = 1'b1;
              last_done = cyc;
              st = 0;
            end
          end
          default: if (cnt != 0) cnt--;
        endcase
        if (st == 1 && cnt == 0) begin
          swd_done = 1'b0;
          swd_ack = 3'($urandom_range(0, 7)); swd_dread = $urandom; swd_perr = 1'($urandom_range(0, 1));
          cnt = $urandom_range(1, 4);
          st = 2;
        end
      end
    end
  end

  initial begin : rsp_monitor
    rsp_t e;
    rsp_ready = 1'b0;
    forever begin
      @(negedge clk);
      rsp_ready = 1'b0;
      if (rst && rsp_valid) begin
        check("rsp_expected", (eq.size() != 0), 1'b1);
        check("cmd_ready_busy", cmd_ready, 1'b0);
        if (eq.size() != 0) begin
          e = eq[0];
          check("rsp_status", rsp_status, e.status);
          check("rsp_ack", rsp_ack, e.ack);
          check("rsp_perr", rsp_perr, e.perr);
          check("rsp_retries", rsp_retries, e.retries);
          check("rsp_rdata", rsp_rdata, e.rdata);
        end
        if ($urandom_range(0, 2) == 0) begin
          rsp_ready = 1'b1;
          @(posedge clk);
          if (eq.size() != 0) void'(eq.pop_front());
        end
      end
    end
  end

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin : main
    resp_t s[$];
    int n;
    repeat (3) @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1'b0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_swd_go", swd_go, 1'b0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_misc", {rsp_ack, rsp_perr, rsp_status}, 32'h0);
    check("rst_rsp_retries", rsp_retries, 32'h0);
    check("rst_swd_fields", {swd_addr32, swd_rnw, swd_apndp}, 32'h0);
    check("rst_swd_dwrite", swd_dwrite, 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    s.delete(); s.push_back(mk(3'b001, 32'habcdef12, 1'b0));
    run(2'b01, 1'b1, 1'b0, 32'h0, s);

    s.delete();
    s.push_back(mk(3'b010, $urandom, 1'b0));
    s.push_back(mk(3'b010, $urandom, 1'b0));
    s.push_back(mk(3'b001, $urandom, 1'b0));
    run(2'b10, 1'b0, 1'b1, 32'hcafef00d, s);

    s.delete();
    for (int i = 0; i < MAXR + 3; i++) s.push_back(mk(3'b010, $urandom, 1'b0));
    run(2'b00, 1'b0, 1'b0, 32'h11223344, s);

    s.delete();
    s.push_back(mk(3'b001, 32'hdeadbeef, 1'b0));
    s.push_back(mk(3'b001, 32'h12345678, 1'b0));
    run(2'b01, 1'b1, 1'b1, 32'h0, s);

    s.delete(); s.push_back(mk(3'b001, 32'h55aa55aa, 1'b1));
    run(2'b10, 1'b1, 1'b0, 32'h0, s);
    s.delete(); s.push_back(mk(3'b010, 32'h1, 1'b1));
    run(2'b00, 1'b1, 1'b1, 32'h0, s);
    s.delete(); s.push_back(mk(3'b111, 32'h77777777, 1'b0));
    run(2'b11, 1'b1, 1'b0, 32'h0, s);
    s.delete(); s.push_back(mk(3'b100, 32'h0, 1'b0));
    run(2'b01, 1'b0, 1'b1, 32'h89abcdef, s);

    // Reset asserted while the transfer is in flight
    s.delete(); s.push_back(mk(3'b001, 32'h0badf00d, 1'b0));
    plan(2'b10, 1'b1, 1'b0, 32'h0, s);
    issue(2'b10, 1'b1, 1'b0, 32'h0);
    n = 0;
    while (swd_done && n < 50) begin @(negedge clk); #1; n++; end
    check("swd_done_low_seen", swd_done, 1'b0);
    @(posedge clk); #1;
    check("pre_rst_addr", swd_addr32, 2'b10);
    rst = 1'b0;
    #1;
    check("arst_swd_go", swd_go, 1'b0);
    check("arst_rsp_valid", rsp_valid, 1'b0);
    check("arst_cmd_ready", cmd_ready, 1'b0);
    check("arst_swd_fields", {swd_addr32, swd_rnw, swd_apndp}, 32'h0);
    xq.delete(); sq.delete(); eq.delete();
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    check("no_rsp_after_rst", eq.size(), 32'h0);

    s.delete(); s.push_back(mk(3'b001, 32'h600dcafe, 1'b0));
    run(2'b01, 1'b1, 1'b0, 32'h0, s);

    for (int c = 0; c < 40; c++) begin
      bit aw;
      aw = ($urandom_range(0, 9) == 0);
      s.delete();
      for (int i = 0; i < 24; i++) s.push_back(rand_resp(aw));
      run(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, s);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
